// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: RV32I fetch stage with PC, in-order variable-latency imem requests, prefetch FIFO, redirect flush; IF_PERF_CNT_EN adds perf counters
module instr_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  input  logic            if_id_ready,
  output logic [XLEN-1:0] if_id_ir,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_npc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_empty,
  output logic [31:0]     perf_flush
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0] outstanding, kill, count;
  logic [AW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [XLEN-1:0] fifo_ir [DEPTH];
  logic [XLEN-1:0] fifo_pc [DEPTH];
  logic [XLEN-1:0] tag_pc [DEPTH];
  logic accept, drop, push, pop;
  assign imem_req = !rst && !redirect_valid && (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accept = imem_req && imem_gnt;
  assign drop = imem_rvalid && kill != '0;
  assign push = imem_rvalid && kill == '0 && !redirect_valid;
  assign if_id_valid = count != '0;
  assign pop = if_id_valid && if_id_ready;
  assign if_id_ir = if_id_valid ? fifo_ir[rd_ptr] : '0;
  assign if_id_pc = if_id_valid ? fifo_pc[rd_ptr] : '0;
  assign if_id_npc = if_id_valid ? fifo_pc[rd_ptr] + XLEN'(PC_STEP) : '0;
  always_ff @(posedge clk) begin
    if (accept) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_ir[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr] <= tag_pc[tag_rd];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      kill <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tag_wr <= '0;
      tag_rd <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      outstanding <= outstanding - CW'(imem_rvalid);
      kill <= outstanding - CW'(imem_rvalid);
      count <= '0;
      rd_ptr <= wr_ptr;
      tag_rd <= tag_wr;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      count <= count + CW'(push) - CW'(pop);
      if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        tag_wr <= tag_wr + 1'b1;
      end
      if (drop) kill <= kill - 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        tag_rd <= tag_rd + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
      perf_empty <= '0;
      perf_flush <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop && perf_fetched != '1);
      perf_stall <= perf_stall + 32'(if_id_valid && !if_id_ready && perf_stall != '1);
      perf_empty <= perf_empty + 32'(!if_id_valid && perf_empty != '1);
      perf_flush <= perf_flush + 32'(redirect_valid && perf_flush != '1);
    end
  end
`endif
`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> outstanding != '0);
  assert property (@(posedge clk) disable iff (rst) (push && !pop) |-> count != CW'(DEPTH));
`endif
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised instruction-fetch stage for the RV32I core.
- Owns the PC and issues word-addressed fetch requests to an instruction memory that has variable latency.
- Buffers returned instructions in a prefetch FIFO, and presents them to decode through a valid/ready handshake together with PC and NPC.
- Supports stall (back-pressure from decode) and redirect (branch/jump) with flush of queued and in-flight fetches.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words
- DEPTH, 4, prefetch FIFO entries; power of two, >=2
- PC_STEP, 1, PC increment per instruction (word addressing, so NPC = PC+1)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (word address)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  XLEN  instruction word
- redirect_valid  in  1  load new PC, flush pipeline
- redirect_pc  in  XLEN  target PC
- if_id_valid  out  1  if_id_* outputs hold a valid instruction
- if_id_ready  in  1  decode accepts this cycle
- if_id_ir  out  XLEN  instruction
- if_id_pc  out  XLEN  PC of instruction
- if_id_npc  out  XLEN  if_id_pc + PC_STEP

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, kill=0; imem_req=0, if_id_valid=0, if_id_ir=0, if_id_pc=0, if_id_npc=0.
- Request issue: imem_req=1 when outstanding + fifo_count < DEPTH and not redirect_valid. imem_addr=fetch_pc.
- Request acceptance: a request is accepted when imem_req & imem_gnt. On acceptance, fetch_pc += PC_STEP (mod 2^XLEN, wrap allowed) and outstanding++. The PC of the accepted request is pushed to an internal tag queue of DEPTH entries.
- Response handling: on imem_rvalid, outstanding--.
  - If kill>0: kill--, and the data is dropped.
  - Otherwise: {rdata, tag_pc} is written to the FIFO. Reserving slots at issue time guarantees no overflow.
- Output: if_id_* are driven combinationally from the FIFO head. if_id_valid = !empty. Pop on if_id_valid & if_id_ready.
- Outputs hold while valid & !ready (stable until accepted).
- Redirect (highest priority, takes effect the next cycle):
  - FIFO and tag queue are cleared; kill = outstanding minus any response consumed the same cycle; fetch_pc = redirect_pc.
  - imem_req=0 in the redirect cycle. The first request at redirect_pc is issued the following cycle.
  - if_id_valid=0 the cycle after redirect.
- Simultaneous events:
  - Pop and push in the same cycle are both allowed with FIFO full.
  - Grant and rvalid in the same cycle net outstanding unchanged.
  - Redirect in the same cycle as grant: the grant is ignored, because imem_req is 0.
- Redirect while kill>0: kill accumulates. Its width is clog2(DEPTH)+1 and it never exceeds DEPTH.
- Latency: minimum 2 cycles from the PC being loaded to if_id_valid, given a 1-cycle memory. At steady state, throughput is 1 instruction/cycle while the memory grants every cycle.
- Reset mid-operation: all state returns to reset values the next edge. Stale responses after reset are the memory's responsibility; the memory must be reset on the same rst.
- Assertions (sim only): imem_rvalid never arrives with outstanding==0; FIFO never overflows.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32, instructions popped to decode), perf_stall (32, cycles with if_id_valid & !if_id_ready), perf_empty (32, cycles with !if_id_valid after reset) and perf_flush (32, redirect count). All counters clear on rst and saturate at all-ones.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then 1-cycle memory, gnt=1, ready=1 -> if_id_pc = 0,1,2,3… on consecutive cycles, npc = pc+1, first valid 2 cycles after rst drops.
- ready=0 for 6 cycles, DEPTH=4 -> imem_req deasserts once 4 slots are reserved. Head holds pc=0 with a stable ir. Releasing ready drains pc 0..3 in order with no loss.
- Memory latency 3, redirect_pc=0x40 while 2 requests are outstanding -> both stale responses are dropped (kill 2→0). Next if_id_pc=0x40, then 0x41.
- Redirect on the same cycle as pop with FIFO full -> next cycle if_id_valid=0, FIFO empty, imem_addr=redirect_pc one cycle later.
- Redirect pc=0xFFFFFFFF -> following fetch addresses 0xFFFFFFFF then 0x00000000; npc of the first = 0x00000000.
- rst asserted with FIFO half full and 1 outstanding -> next cycle all outputs 0, imem_addr=RESET_PC. With IF_PERF_CNT_EN, counters read 0.
